alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_ref_model.sv | 56 +++++
 rtl/alu_op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: op encodings,
// FSM state type and settle-counter width.
package alu_seq_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the gate-level ALU. Mirrors the ALU's own
// formulas: SUB is a + ~b + 1, SLT flags come from a + ~b with carry-in 0,
// logic ops report carry = overflow = 0.
module alu_ref_model
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;
    logic [WIDTH:0] sum_slt;

    // Evaluate all three adder forms, then select by op.
    always_comb begin
        sum_add  = {1'b0, a} + {1'b0, b};
        sum_sub  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        sum_slt  = {1'b0, a} + {1'b0, ~b};
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum_add[WIDTH-1:0];
                carry    = sum_add[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = sum_sub[WIDTH-1:0];
                carry    = sum_sub[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: begin
                result   = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1]};
                carry    = sum_slt[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sum_slt[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Clocked initiator for the combinational ALU: accepts an op over a
// valid/ready handshake, drives registered operands/selector, waits
// SETTLE_CYCLES for ripple settling, then returns the captured result.
// Optional feature macro: ALU_SEQ_SELFCHECK_EN (golden-model compare,
// sticky chk_err). Without it chk_err is tied low.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             chk_err
);

    // state  | meaning
    // IDLE   | waiting for a request (ready once out of reset for one edge)
    // SETTLE | ALU inputs driven, counting down settle cycles
    // RESP   | captured result presented, waiting for rsp_ready

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q;
    logic             accept;
    logic             capture;

    // Next-state, counter and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        capture   = 1'b0;
        req_ready = armed_q && (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; armed_q keeps req_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

    // ALU operand/selector registers change only on request acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_op;
        end
    end

    // Response registers load on the capture edge and hold through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else if (capture) begin
            rsp_result   <= alu_out;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
        end
    end

`ifdef ALU_SEQ_SELFCHECK_EN
    logic [WIDTH-1:0] ref_result;
    logic             ref_carry;
    logic             ref_overflow;
    logic             ref_zero;
    logic             arith_op;
    logic             mismatch;
    logic             chk_err_q;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a        (alu_a),
        .b        (alu_b),
        .op       (alu_sel),
        .result   (ref_result),
        .carry    (ref_carry),
        .overflow (ref_overflow),
        .zero     (ref_zero)
    );

    // Carry/overflow are only meaningful for the adder-based ops.
    always_comb begin
        arith_op = (alu_sel == OP_ADD) || (alu_sel == OP_SUB) || (alu_sel == OP_SLT);
        mismatch = (alu_out != ref_result) || (alu_zero != ref_zero) ||
                   (arith_op && ((alu_carry != ref_carry) || (alu_overflow != ref_overflow)));
    end

    // Sticky error flag, sampled on the capture edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (capture && mismatch) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU stub.
module tb_alu_op_sequencer;

    localparam int W = 32;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [2:0]   req_op = '0;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_out;
    logic         alu_carry, alu_overflow, alu_zero;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_overflow, rsp_zero;
    logic         chk_err;
    logic         fault = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .chk_err(chk_err)
    );

    // Arithmetic-level ALU behaviour: returns {carry, overflow, result}.
    function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        longint ua, ub, sa, sb, t;
        logic [W-1:0] r, d;
        logic c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: begin r = a + b; c = (ua + ub) > 64'sd4294967295; t = sa + sb;
                        v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            3'd1: begin r = a - b; c = (ua >= ub); t = sa - sb;
                        v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            3'd3: begin d = a - b; r = {31'd0, d[31]}; c = (ua > ub); t = sa - sb - 64'sd1;
                        v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            3'd2: r = a ^ b;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {c, v, r};
    endfunction

    // ALU stub; fault flips result bit 0.
    logic [W+1:0] stub_v;
    always_comb begin
        stub_v       = alu_fn(alu_a, alu_b, alu_sel);
        alu_out      = stub_v[W-1:0] ^ {{(W-1){1'b0}}, fault};
        alu_carry    = stub_v[W+1];
        alu_overflow = stub_v[W];
        alu_zero     = (alu_out == '0);
    end

    // Transaction-level model: edges since acceptance, pending response.
    logic         m_armed, m_busy, m_rsp_valid, m_chk;
    int           m_t;
    logic [W-1:0] m_a, m_b, m_res;
    logic [2:0]   m_op;
    logic         m_c, m_v, m_z;
    logic [W+1:0] m_tmp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_armed = 0; m_busy = 0; m_rsp_valid = 0; m_chk = 0; m_t = 0;
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_c = 0; m_v = 0; m_z = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (m_rsp_valid) begin
            if (rsp_ready) m_rsp_valid = 0;
        end else if (m_busy) begin
            m_t++;
            if (m_t == S) begin
                m_tmp = alu_fn(m_a, m_b, m_op);
                m_res = m_tmp[W-1:0] ^ {{(W-1){1'b0}}, fault};
                m_c = m_tmp[W+1];
                m_v = m_tmp[W];
                m_z = (m_res == '0);
`ifdef ALU_SEQ_SELFCHECK_EN
                if (fault) m_chk = 1;
`endif
                m_busy = 0;
                m_rsp_valid = 1;
            end
        end else if (req_valid) begin
            m_a = req_a; m_b = req_b; m_op = req_op; m_busy = 1; m_t = 0;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("req_ready", W'(req_ready), W'(m_armed && !m_busy && !m_rsp_valid));
        check("rsp_valid", W'(rsp_valid), W'(m_rsp_valid));
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_sel", W'(alu_sel), W'(m_op));
        check("rsp_result", rsp_result, m_res);
        check("rsp_flags", W'({rsp_carry, rsp_overflow, rsp_zero}), W'({m_c, m_v, m_z}));
        check("chk_err", W'(chk_err), W'(m_chk));
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         output logic [W-1:0] res, output logic [2:0] cvz, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) check("req_ready_timeout", W'(req_ready), W'(1));
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
        if (!rsp_valid) check("rsp_valid_timeout", W'(rsp_valid), W'(1));
        res = rsp_result;
        cvz = {rsp_carry, rsp_overflow, rsp_zero};
        if (rsp_ready) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [W-1:0] r, r0, a0;
    logic [2:0]   f, f0;
    int           lat;
    logic         exp_chk;

    initial begin
`ifdef ALU_SEQ_SELFCHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_req_ready", W'(req_ready), W'(0));
        check("reset_alu_a", alu_a, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", W'(req_ready), W'(1));

        do_op(32'd10, 32'd1, 3'd0, r, f, lat);
        check("add_result", r, 32'd11);
        check("add_flags", W'(f), W'(3'b000));
        check("add_latency", W'(lat), W'(S));
        do_op(32'd0, 32'd1, 3'd1, r, f, lat);
        check("sub_result", r, 32'hFFFF_FFFF);
        check("sub_flags", W'(f), W'(3'b000));
        do_op(32'd2, 32'd1, 3'd3, r, f, lat);
        check("slt_result", r, 32'd0);
        check("slt_zero", W'(f[0]), W'(1));
        do_op(32'hFFFF_0000, 32'hFFFF_0000, 3'd4, r, f, lat);
        check("and_result", r, 32'hFFFF_0000);
        do_op(32'h5555_5555, 32'hAAAA_AAAA, 3'd6, r, f, lat);
        check("nor_result", r, 32'd0);
        check("nor_zero", W'(f[0]), W'(1));
        do_op(32'h7FFF_FFFF, 32'd1, 3'd0, r, f, lat);
        check("add_ovf", W'({r, f}), W'({32'h8000_0000, 3'b010}));
        do_op(32'h8000_0000, 32'd1, 3'd1, r, f, lat);
        check("sub_ovf", r, 32'h7FFF_FFFF);
        check("sub_ovf_flags", W'(f), W'(3'b110));

        // Backpressure with a competing request.
        rsp_ready = 1'b0;
        do_op(32'd100, 32'd23, 3'd0, r0, f0, lat);
        a0 = alu_a;
        req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_op = 3'd2; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", W'(req_ready), W'(0));
            check("bp_rsp_result", rsp_result, 32'd123);
            check("bp_alu_a", alu_a, a0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_hs", W'(req_ready), W'(1));
        @(negedge clk);
        check("bp_accept_new", alu_a, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        repeat (S + 2) @(negedge clk);

        // Reset in the middle of SETTLE.
        do_op(32'd5, 32'd6, 3'd7, r, f, lat);
        req_a = 32'd77; req_b = 32'd1; req_op = 3'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", W'(rsp_valid), W'(0));
        check("rst_req_ready", W'(req_ready), W'(0));
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_rsp_result", rsp_result, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after_release", W'(req_ready), W'(1));

        // Faulty ALU on one op; chk_err must latch and persist.
        fault = 1'b1;
        do_op(32'd10, 32'd1, 3'd0, r, f, lat);
        fault = 1'b0;
        check("fault_result", r, 32'd10);
        check("chk_err_set", W'(chk_err), W'(exp_chk));
        do_op(32'd3, 32'd4, 3'd0, r, f, lat);
        check("chk_err_sticky", W'(chk_err), W'(exp_chk));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("chk_err_cleared", W'(chk_err), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            req_a = pick();
            req_b = pick();
            req_op = 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (S + 4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
